pipe_stage_hs: RTL and testbench

//  Parametrised pipeline stage register (successor of the fixed MEM/WB latch) with valid/ready handshake.

---
 rtl/pipe_stage_hs.sv | 137 +++++++++++++
 tb/tb_pipe_stage_hs.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with a 2-entry skid buffer.
// Optional perf counters when PIPE_PERF_EN is defined.
//
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   flush_i              sync flush of all held entries
//   valid_i/ready_o      upstream handshake (ready_o registered)
//   wb_i/addr_i/data_i/rd_i  payload in
//   valid_o/ready_i      downstream handshake
//   wb_o/addr_o/data_o/rd_o  payload out (wb_o gated by valid_o)
//   stall_cnt_o          cycles valid_o=1 & ready_i=0
//   bubble_cnt_o         cycles valid_o=0
// Macro: PIPE_PERF_EN enables the saturating counters.
module pipe_stage_hs #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] wb_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] wb_o,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int PW = CTRL_W + 2*DATA_W + RD_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          ready_q;
  logic [PW-1:0] in_pl;
  logic          acc, pop;

  assign in_pl = {wb_i, addr_i, data_i, rd_i};
  assign valid_o = (state_q != EMPTY);
  assign ready_o = ready_q;
  assign acc = valid_i & ready_q;
  assign pop = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_pl;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_d = in_pl;
          end else if (acc) begin
            state_d = TWO;
            skid_d  = in_pl;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ready is a flop: it looks one state ahead
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
    end
  end

  assign wb_o   = main_q[PW-1 -: CTRL_W]
                & {CTRL_W{valid_o}};
  assign addr_o = main_q[RD_W+DATA_W +: DATA_W];
  assign data_o = main_q[RD_W +: DATA_W];
  assign rd_o   = main_q[RD_W-1:0];

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (valid_o && !ready_i && !(&stall_q))
        stall_q <= stall_q + 1'b1;
      if (!valid_o && !(&bubble_q))
        bubble_q <= bubble_q + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: random + directed check of pipe_stage_hs
// against a queue-based reference model.
module tb_pipe_stage_hs;

  localparam int CW = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int NW = 4;
  localparam int PW = CW + 2*DW + RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [CW-1:0] wb_i = '0;
  logic [DW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [RW-1:0] rd_i = '0;
  logic          ready_o, valid_o;
  logic [CW-1:0] wb_o;
  logic [DW-1:0] addr_o, data_o;
  logic [RW-1:0] rd_o;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] q[$];
  int            m_stall, m_bubble;
  bit            perf_on;

  always #5 clk = ~clk;

  pipe_stage_hs #(
    .CTRL_W(CW), .DATA_W(DW), .RD_W(RW), .CNT_W(NW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .valid_i(valid_i), .ready_o(ready_o),
    .wb_i(wb_i), .addr_i(addr_i),
    .data_i(data_i), .rd_i(rd_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .wb_o(wb_o), .addr_o(addr_o),
    .data_o(data_o), .rd_o(rd_o),
    .stall_cnt_o(stall_cnt),
    .bubble_cnt_o(bubble_cnt)
  );

  task automatic check(input string tag,
                       input logic [PW-1:0] got,
                       input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (perf_on && v < (1 << NW) - 1) ? v + 1 : v;
  endfunction

  task automatic check_all(input bit cnts);
    logic [PW-1:0] h;
    check("valid_o", valid_o, q.size() != 0);
    check("ready_o", ready_o, q.size() < 2);
    if (q.size() != 0) begin
      h = q[0];
      check("payload", {wb_o, addr_o, data_o, rd_o}, h);
    end else begin
      check("wb_bubble", wb_o, '0);
    end
    if (cnts) begin
      check("stall_cnt", stall_cnt, m_stall);
      check("bubble_cnt", bubble_cnt, m_bubble);
    end
  endtask

  // drive one cycle of inputs, update model at the edge,
  // check at the following falling edge
  task automatic step(input bit v, input bit r, input bit f,
                      input logic [PW-1:0] pl,
                      input bit cnts);
    bit m_valid, m_ready;
    valid_i = v;
    ready_i = r;
    flush = f;
    {wb_i, addr_i, data_i, rd_i} = pl;
    m_valid = q.size() != 0;
    m_ready = q.size() < 2;
    @(posedge clk);
    if (m_valid && !r) m_stall = sat(m_stall);
    if (!m_valid) m_bubble = sat(m_bubble);
    if (f) begin
      q.delete();
    end else begin
      if (m_valid && r) void'(q.pop_front());
      if (v && m_ready) q.push_back(pl);
    end
    @(negedge clk);
    check_all(cnts);
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] p;
    p = {$urandom, $urandom, $urandom};
    return p;
  endfunction

  function automatic logic [PW-1:0] mk(input logic [CW-1:0] w,
                                       input logic [DW-1:0] a);
    return {w, a, a ^ 32'hA5A5_0000, a[RW-1:0]};
  endfunction

  task automatic do_reset();
    valid_i = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_stall = 0;
    m_bubble = 0;
  endtask

  initial begin
`ifdef PIPE_PERF_EN
    perf_on = 1'b1;
`else
    perf_on = 1'b0;
`endif
    m_stall = 0;
    m_bubble = 0;
    do_reset();
    // reset state
    check("rst_valid", valid_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_pl", {wb_o, addr_o, data_o, rd_o}, '0);
    check("rst_cnt", {stall_cnt, bubble_cnt}, '0);

    // streaming, no back-pressure
    step(1, 1, 0, mk(2'b01, 32'h10), 1);
    step(1, 1, 0, mk(2'b10, 32'h14), 1);
    step(1, 1, 0, mk(2'b11, 32'h18), 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);

    // back-pressure fills skid, then drain
    step(1, 0, 0, mk(2'b01, 32'h100), 1);
    step(1, 0, 0, mk(2'b10, 32'h104), 1);
    check("bp_ready_low", ready_o, 1'b0);
    check("bp_hold_A", addr_o, 32'h100);
    step(1, 0, 0, mk(2'b11, 32'h108), 1);
    step(0, 1, 0, '0, 1);
    check("drain_B", addr_o, 32'h104);
    check("drain_ready", ready_o, 1'b1);
    step(0, 1, 0, '0, 1);

    // flush in TWO with a live input
    step(1, 0, 0, mk(2'b01, 32'h200), 1);
    step(1, 0, 0, mk(2'b01, 32'h204), 1);
    step(1, 0, 1, mk(2'b11, 32'h208), 1);
    check("flush_valid", valid_o, 1'b0);
    check("flush_wb", wb_o, '0);
    check("flush_ready", ready_o, 1'b1);
    step(0, 1, 0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 30) == 0,
           rnd_pl(), 1);
    end

    // async reset mid-stream, away from the edge
    step(1, 0, 0, mk(2'b11, 32'h300), 1);
    step(1, 0, 0, mk(2'b11, 32'h304), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid_o, 1'b0);
    check("arst_ready", ready_o, 1'b1);
    check("arst_pl", {wb_o, addr_o, data_o, rd_o}, '0);
    check("arst_cnt", {stall_cnt, bubble_cnt}, '0);
    q.delete();
    m_stall = 0;
    m_bubble = 0;
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, mk(2'b10, 32'h400), 1);
    check("resume_addr", addr_o, 32'h400);
    step(0, 1, 0, '0, 1);

    // stall counter saturation
    do_reset();
    step(1, 0, 0, mk(2'b01, 32'h500), 1);
    for (int i = 0; i < 20; i++)
      step(0, 0, 0, '0, 1);
    check("stall_sat", stall_cnt,
          perf_on ? (1 << NW) - 1 : 0);
    check("hold_payload", addr_o, 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
